// File: rtl/ahb_nslave_interconnect_if.sv
// ahb_nslave_interconnect_if: master-facing and slave-facing AHB-Lite signals of the interconnect.
// The master modport is the interconnect's port toward the core; the slave modport faces the slaves.
interface ahb_nslave_interconnect_if #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [1:0] htrans;
    logic hwrite;
    logic [2:0] hsize;
    logic [3:0] hprot;
    logic [DATA_W-1:0] hwdata;
    logic is_signed;
    logic [DATA_W-1:0] hr_data;
    logic hready;
    logic hresp;
    logic timeout_flag;
    logic [NUM_SLAVES-1:0] hsel;
    logic [ADDR_W-1:0] Haddr;
    logic [1:0] Htrans;
    logic Hwrite;
    logic [2:0] Hsize;
    logic [3:0] Hprot;
    logic [DATA_W-1:0] Hwdata;
    logic Is_signed;
    logic [NUM_SLAVES*DATA_W-1:0] slv_hrdata;
    logic [NUM_SLAVES-1:0] slv_hready;
    logic [NUM_SLAVES-1:0] slv_hresp;
    modport master (
        input haddr, htrans, hwrite, hsize, hprot, hwdata, is_signed,
        output hr_data, hready, hresp, timeout_flag
    );
    modport slave (
        output hsel, Haddr, Htrans, Hwrite, Hsize, Hprot, Hwdata, Is_signed,
        input slv_hrdata, slv_hready, slv_hresp
    );
endinterface

// File: rtl/ahb_nslave_interconnect.sv
// ahb_nslave_interconnect: AHB-Lite core-to-N-slave interconnect with base/mask decode,
// built-in ERROR default slave and a wait-state watchdog.
module ahb_nslave_interconnect #(
    parameter int NUM_SLAVES = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic clk,
    input logic reset,
    ahb_nslave_interconnect_if.master mst,
    ahb_nslave_interconnect_if.slave slv
);
    localparam int SW = $clog2(NUM_SLAVES + 1);
    localparam logic [SW-1:0] DEF = SW'(NUM_SLAVES);
    localparam int WW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ERR1, ERR2} tstate_t;
    tstate_t tstate_q, tstate_d;
    logic dp_active_q, dp_active_d;
    logic [SW-1:0] dp_sel_q, dp_sel_d, dec_idx;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic timeout_q, timeout_d;
    logic s_rdy, s_resp, sdp, wait_s, trip;
    logic [DATA_W-1:0] s_rdata;
    assign slv.Haddr = mst.haddr;
    assign slv.Htrans = mst.htrans;
    assign slv.Hwrite = mst.hwrite;
    assign slv.Hsize = mst.hsize;
    assign slv.Hprot = mst.hprot;
    assign slv.Hwdata = mst.hwdata;
    assign slv.Is_signed = mst.is_signed;
    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        dec_idx = DEF;
        for (int i = NUM_SLAVES - 1; i >= 0; i--)
            if ((mst.haddr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])
                dec_idx = SW'(i);
    end
    always_comb begin
        slv.hsel = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            slv.hsel[i] = dec_idx == SW'(i) && mst.htrans[1] && tstate_q == IDLE;
    end
    always_comb begin
        s_rdy = 1'b0;
        s_resp = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dp_sel_q == SW'(i)) begin
                s_rdy = slv.slv_hready[i];
                s_resp = slv.slv_hresp[i];
                s_rdata = slv.slv_hrdata[i*DATA_W +: DATA_W];
            end
        end
    end
    assign sdp = dp_active_q && dp_sel_q != DEF;
    assign wait_s = tstate_q == IDLE && sdp && !s_rdy;
    // Trip on the wait cycle that makes TIMEOUT_CYCLES-1 in a row, so ERR1 lands in data-phase cycle TIMEOUT_CYCLES.
    assign trip = TIMEOUT_CYCLES != 0 && wait_s && int'(wcnt_q) + 2 >= TIMEOUT_CYCLES;
    assign mst.hready = tstate_q == ERR1 ? 1'b0 : tstate_q == ERR2 ? 1'b1 : !dp_active_q ? 1'b1 : sdp ? s_rdy : 1'b0;
    assign mst.hresp = tstate_q != IDLE ? 1'b1 : sdp ? s_resp : dp_active_q;
    assign mst.hr_data = tstate_q == IDLE && sdp ? s_rdata : '0;
    assign mst.timeout_flag = timeout_q;
    always_comb begin
        dp_active_d = mst.hready ? mst.htrans[1] : dp_active_q;
        dp_sel_d = mst.hready ? dec_idx : dp_sel_q;
        wcnt_d = wait_s && !trip ? wcnt_q + 1'b1 : '0;
        timeout_d = timeout_q | trip;
        tstate_d = tstate_q == ERR1 ? ERR2
                 : (mst.hready && mst.htrans[1] && dec_idx == DEF) || trip ? ERR1
                 : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate_q <= IDLE;
            dp_active_q <= 1'b0;
            dp_sel_q <= '0;
            wcnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            dp_active_q <= dp_active_d;
            dp_sel_q <= dp_sel_d;
            wcnt_q <= wcnt_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_ahb_nslave_interconnect.sv
// tb_ahb_nslave_interconnect: directed stimulus against a cycle-level behavioural model of the interconnect,
// with a second instance covering an overlapping address map.
module tb_ahb_nslave_interconnect;
    localparam int TMO = 4;
    logic clk = 1'b0;
    logic reset;
    int n_chk = 0;
    int n_pass = 0;
    always #5 clk = ~clk;
    ahb_nslave_interconnect_if #(.NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32)) bus ();
    ahb_nslave_interconnect_if #(.NUM_SLAVES(2), .ADDR_W(32), .DATA_W(32)) busb ();
    ahb_nslave_interconnect #(.TIMEOUT_CYCLES(TMO)) dut_a (
        .clk(clk), .reset(reset), .mst(bus), .slv(bus)
    );
    ahb_nslave_interconnect #(
        .SLAVE_BASE(64'h0),
        .SLAVE_MASK({32'h0000_0000, 32'hFFFF_0000}),
        .TIMEOUT_CYCLES(TMO)
    ) dut_b (
        .clk(clk), .reset(reset), .mst(busb), .slv(busb)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Default map: 0x0000_xxxx -> slave 0, 0x0001_xxxx -> slave 1, anything else -> default slave (2).
    function automatic int decode(input logic [31:0] a);
        if (a[31:16] == 16'h0000) return 0;
        if (a[31:16] == 16'h0001) return 1;
        return 2;
    endfunction
    // Model: m_err = ERROR cycles still to show (2 = first), m_kind = data-phase target (-1 none), m_wait = waits seen.
    int m_err = 0;
    int m_kind = -1;
    int m_wait = 0;
    logic m_tflag = 1'b0;
    int e_dec;
    logic e_ready, e_resp;
    logic [31:0] e_rdata;
    logic [1:0] e_hsel;
    always_comb begin
        e_dec = decode(bus.haddr);
        e_ready = 1'b1;
        e_resp = 1'b0;
        e_rdata = '0;
        e_hsel = '0;
        if (m_err == 2) begin
            e_ready = 1'b0;
            e_resp = 1'b1;
        end else if (m_err == 1) begin
            e_resp = 1'b1;
        end else if (m_kind == 0 || m_kind == 1) begin
            e_ready = m_kind == 0 ? bus.slv_hready[0] : bus.slv_hready[1];
            e_resp = m_kind == 0 ? bus.slv_hresp[0] : bus.slv_hresp[1];
            e_rdata = m_kind == 0 ? bus.slv_hrdata[31:0] : bus.slv_hrdata[63:32];
        end
        if (m_err == 0 && bus.htrans[1] && e_dec < 2) e_hsel = e_dec == 0 ? 2'b01 : 2'b10;
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_err <= 0;
            m_kind <= -1;
            m_wait <= 0;
            m_tflag <= 1'b0;
        end else if (m_err == 2) begin
            m_err <= 1;
        end else if (e_ready) begin
            m_kind <= bus.htrans[1] ? e_dec : -1;
            m_wait <= 0;
            m_err <= (bus.htrans[1] && e_dec == 2) ? 2 : 0;
        end else if (m_wait + 1 == TMO - 1) begin
            m_err <= 2;
            m_tflag <= 1'b1;
            m_wait <= 0;
        end else begin
            m_wait <= m_wait + 1;
        end
    end
    always @(negedge clk) begin
        chk("hready", 64'(bus.hready), 64'(e_ready));
        chk("hresp", 64'(bus.hresp), 64'(e_resp));
        chk("hr_data", 64'(bus.hr_data), 64'(e_rdata));
        chk("hsel", 64'(bus.hsel), 64'(e_hsel));
        chk("timeout_flag", 64'(bus.timeout_flag), 64'(m_tflag));
        chk("bcast", 64'({bus.Haddr, bus.Htrans, bus.Hwrite, bus.Hsize, bus.Hprot, bus.Is_signed}),
            64'({bus.haddr, bus.htrans, bus.hwrite, bus.hsize, bus.hprot, bus.is_signed}));
        chk("bcast_wdata", 64'(bus.Hwdata), 64'(bus.hwdata));
    end
    initial begin
        reset = 1'b1;
        bus.haddr = '0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hsize = 3'd2;
        bus.hprot = 4'h3;
        bus.hwdata = '0;
        bus.is_signed = 1'b0;
        bus.slv_hrdata = {32'h1111_1111, 32'hDEAD_BEEF};
        bus.slv_hready = 2'b11;
        bus.slv_hresp = 2'b00;
        busb.haddr = '0;
        busb.htrans = 2'b00;
        busb.hwrite = 1'b0;
        busb.hsize = 3'd2;
        busb.hprot = 4'h0;
        busb.hwdata = '0;
        busb.is_signed = 1'b0;
        busb.slv_hrdata = '0;
        busb.slv_hready = 2'b11;
        busb.slv_hresp = 2'b00;
        @(negedge clk);
        chk("rst_hready", 64'(bus.hready), 64'd1);
        chk("rst_hresp", 64'(bus.hresp), 64'd0);
        chk("rst_hr_data", 64'(bus.hr_data), 64'd0);
        chk("rst_hsel_idle", 64'(bus.hsel), 64'd0);
        tick();
        reset = 1'b0;
        // Read slave 0
        bus.haddr = 32'h0000_0010;
        bus.htrans = 2'b10;
        bus.is_signed = 1'b1;
        #1 chk("rd0_hsel", 64'(bus.hsel), 64'h1);
        tick();
        bus.htrans = 2'b00;
        #1 chk("rd0_data", 64'(bus.hr_data), 64'hDEAD_BEEF);
        chk("rd0_ready", 64'({bus.hready, bus.hresp}), 64'b10);
        // Pipelined write slave 1 then read slave 0
        tick();
        bus.haddr = 32'h0001_0004;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b1;
        #1 chk("pipe_hsel1", 64'(bus.hsel), 64'h2);
        tick();
        bus.haddr = 32'h0000_0008;
        bus.hwrite = 1'b0;
        bus.hwdata = 32'hCAFE_F00D;
        #1 chk("pipe_hsel0", 64'(bus.hsel), 64'h1);
        chk("pipe_resp1", 64'(bus.hr_data), 64'h1111_1111);
        tick();
        bus.htrans = 2'b00;
        #1 chk("pipe_resp0", 64'(bus.hr_data), 64'hDEAD_BEEF);
        chk("pipe_ready0", 64'(bus.hready), 64'd1);
        // Unmapped access -> two-cycle ERROR
        tick();
        bus.haddr = 32'h8000_0000;
        bus.htrans = 2'b10;
        #1 chk("def_hsel", 64'(bus.hsel), 64'h0);
        tick();
        bus.htrans = 2'b00;
        #1 chk("def_err1", 64'({bus.hready, bus.hresp}), 64'b01);
        tick();
        #1 chk("def_err2", 64'({bus.hready, bus.hresp}), 64'b11);
        tick();
        #1 chk("def_idle", 64'({bus.hready, bus.hresp}), 64'b10);
        // Watchdog on slave 1
        tick();
        bus.haddr = 32'h0001_0000;
        bus.htrans = 2'b10;
        #1 chk("wd_hsel", 64'(bus.hsel), 64'h2);
        tick();
        bus.htrans = 2'b00;
        bus.slv_hready = 2'b01;
        #1 chk("wd_c1", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b000);
        tick();
        tick();
        #1 chk("wd_c3", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b000);
        tick();
        #1 chk("wd_err1", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b011);
        tick();
        #1 chk("wd_err2", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b111);
        tick();
        #1 chk("wd_idle", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b101);
        bus.slv_hready = 2'b11;
        bus.haddr = 32'h0001_0020;
        bus.htrans = 2'b10;
        tick();
        bus.htrans = 2'b00;
        #1 chk("wd_after", 64'({bus.hr_data, bus.hready, bus.hresp, bus.timeout_flag}), {32'h1111_1111, 3'b101});
        // Slave ERROR forwarded as-is
        tick();
        bus.haddr = 32'h0000_0020;
        bus.htrans = 2'b10;
        tick();
        bus.htrans = 2'b00;
        bus.slv_hready = 2'b10;
        bus.slv_hresp = 2'b01;
        #1 chk("serr_1", 64'({bus.hready, bus.hresp}), 64'b01);
        tick();
        bus.slv_hready = 2'b11;
        #1 chk("serr_2", 64'({bus.hready, bus.hresp}), 64'b11);
        tick();
        bus.slv_hresp = 2'b00;
        // Reset during ERR1
        bus.haddr = 32'h4000_0000;
        bus.htrans = 2'b10;
        tick();
        bus.htrans = 2'b00;
        #1 chk("rerr_pre", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b011);
        reset = 1'b1;
        #1 chk("rerr_post", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b100);
        tick();
        reset = 1'b0;
        // Reset during a slave wait
        bus.haddr = 32'h0000_0030;
        bus.htrans = 2'b10;
        tick();
        bus.htrans = 2'b00;
        bus.slv_hready = 2'b10;
        #1 chk("rwait_pre", 64'(bus.hready), 64'd0);
        reset = 1'b1;
        #1 chk("rwait_post", 64'({bus.hready, bus.hresp, bus.timeout_flag}), 64'b100);
        tick();
        reset = 1'b0;
        bus.slv_hready = 2'b11;
        bus.haddr = 32'h0000_0010;
        bus.htrans = 2'b10;
        #1 chk("post_rst_hsel", 64'(bus.hsel), 64'h1);
        tick();
        bus.htrans = 2'b00;
        #1 chk("post_rst_data", 64'({bus.hr_data, bus.hready, bus.hresp}), {32'hDEAD_BEEF, 2'b10});
        // Overlapping map on the second instance
        busb.haddr = 32'h0000_0100;
        busb.htrans = 2'b10;
        #1 chk("ovl_lo", 64'(busb.hsel), 64'h1);
        busb.haddr = 32'h0002_0000;
        #1 chk("ovl_hi", 64'(busb.hsel), 64'h2);
        busb.htrans = 2'b01;
        #1 chk("ovl_busy", 64'(busb.hsel), 64'h0);
        tick();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
